mem_port_arbiter: RTL and testbench

Shares the single-ported unified RAM between the fetch stage (read-only) and the memory stage (read/write) of the 5-stage pipeline. Grants one access at a time, with fixed priority to the memory stage. Generates per-stage stall signals, handles cancelling an in-flight fetch on branch flush, and flags misaligned word accesses. Sits between the IF/MEM stage logic and the RAM model, alongside the hazard stall logic in the pipeline control path.

---
 rtl/mem_arb_defs.sv | 14 +
 rtl/mem_arb_hold.sv | 32 +++
 rtl/mem_port_arbiter.sv | 143 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_defs.sv
// Shared encodings and default widths for the unified-RAM port arbiter.
package mem_arb_defs;

    localparam int unsigned DEF_ADDR_W = 16;
    localparam int unsigned DEF_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        BUSY_IF  = 2'b01,
        BUSY_MEM = 2'b10,
        DRAIN    = 2'b11
    } arb_state_t;

endpackage

// File: rtl/mem_arb_hold.sv
// Holding registers that keep the issued RAM address/control stable until ram_done.
module mem_arb_hold
    import mem_arb_defs::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] cap_addr,
    input  logic              cap_wr,
    input  logic [DATA_W-1:0] cap_wdata,
    output logic [ADDR_W-1:0] addr,
    output logic              wr,
    output logic [DATA_W-1:0] wdata
);

    // Capture the selected request on issue; clear on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr  <= '0;
            wr    <= 1'b0;
            wdata <= '0;
        end else if (load) begin
            addr  <= cap_addr;
            wr    <= cap_wr;
            wdata <= cap_wdata;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported RAM between fetch (read-only) and memory stage,
// memory stage first; cancels fetches on flush and rejects odd addresses.
module mem_port_arbiter
    import mem_arb_defs::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    input  logic              mem_req,
    input  logic              mem_wr,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              ram_done,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              ram_en,
    output logic              ram_wr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    output logic              mem_done,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              stall_IF,
    output logic              stall_MEM,
    output logic              err
);

    arb_state_t        state;
    arb_state_t        next_state;
    logic              load;
    logic [ADDR_W-1:0] hold_addr;
    logic              hold_wr;
    logic [DATA_W-1:0] hold_wdata;

    // The issue-cycle RAM drive is exactly what must be held afterwards.
    mem_arb_hold #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_hold (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .cap_addr  (ram_addr),
        .cap_wr    (ram_wr),
        .cap_wdata (ram_wdata),
        .addr      (hold_addr),
        .wr        (hold_wr),
        .wdata     (hold_wdata)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Requester selection, RAM drive, completion and stall generation.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        ram_en     = 1'b0;
        ram_wr     = 1'b0;
        ram_addr   = '0;
        ram_wdata  = '0;
        if_done    = 1'b0;
        if_rdata   = '0;
        mem_done   = 1'b0;
        mem_rdata  = '0;
        err        = 1'b0;
        stall_IF   = 1'b0;
        stall_MEM  = 1'b0;

        if (!rst) begin
            case (state)
                IDLE: begin
                    if (mem_req) begin
                        if (mem_addr[0]) begin
                            err      = 1'b1;
                            mem_done = 1'b1;
                        end else begin
                            ram_en     = 1'b1;
                            ram_wr     = mem_wr;
                            ram_addr   = mem_addr;
                            ram_wdata  = mem_wdata;
                            load       = 1'b1;
                            next_state = BUSY_MEM;
                        end
                    end else if (if_req && !if_flush) begin
                        if (if_addr[0]) begin
                            err     = 1'b1;
                            if_done = 1'b1;
                        end else begin
                            ram_en     = 1'b1;
                            ram_addr   = if_addr;
                            load       = 1'b1;
                            next_state = BUSY_IF;
                        end
                    end
                end
                BUSY_IF: begin
                    ram_wr    = hold_wr;
                    ram_addr  = hold_addr;
                    ram_wdata = hold_wdata;
                    if (ram_done) begin
                        next_state = IDLE;
                        if (!if_flush) begin
                            if_done  = 1'b1;
                            if_rdata = ram_rdata;
                        end
                    end else if (if_flush) begin
                        next_state = DRAIN;
                    end
                end
                BUSY_MEM: begin
                    ram_wr    = hold_wr;
                    ram_addr  = hold_addr;
                    ram_wdata = hold_wdata;
                    if (ram_done) begin
                        next_state = IDLE;
                        mem_done   = 1'b1;
                        mem_rdata  = ram_rdata;
                    end
                end
                DRAIN: begin
                    ram_wr    = hold_wr;
                    ram_addr  = hold_addr;
                    ram_wdata = hold_wdata;
                    if (ram_done) next_state = IDLE;
                end
                default: next_state = IDLE;
            endcase

            stall_IF  = if_req & ~if_done & ~if_flush;
            stall_MEM = mem_req & ~mem_done;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: the bench plays both pipeline stages and the RAM.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_flush;
    logic        mem_req;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        ram_done;
    logic [15:0] ram_rdata;
    logic        ram_en;
    logic        ram_wr;
    logic [15:0] ram_addr;
    logic [15:0] ram_wdata;
    logic        if_done;
    logic [15:0] if_rdata;
    logic        mem_done;
    logic [15:0] mem_rdata;
    logic        stall_IF;
    logic        stall_MEM;
    logic        err;

    int vectors;
    int miscompares;

    mem_port_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_flush  (if_flush),
        .mem_req   (mem_req),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .ram_done  (ram_done),
        .ram_rdata (ram_rdata),
        .ram_en    (ram_en),
        .ram_wr    (ram_wr),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .if_done   (if_done),
        .if_rdata  (if_rdata),
        .mem_done  (mem_done),
        .mem_rdata (mem_rdata),
        .stall_IF  (stall_IF),
        .stall_MEM (stall_MEM),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance past the next rising edge; inputs change here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Move to the sampling point in the middle of the cycle.
    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        if_req    = 1'b0;
        if_addr   = '0;
        if_flush  = 1'b0;
        mem_req   = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        ram_done  = 1'b0;
        ram_rdata = '0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();

        // Reset state
        sample();
        check_vec("rst_ram_en", 32'(ram_en), 32'd0);
        check_vec("rst_ram_addr", 32'(ram_addr), 32'd0);
        check_vec("rst_stalls", 32'({stall_IF, stall_MEM, err}), 32'd0);
        check_vec("rst_state", 32'(dut.state), 32'd0);
        tick();
        rst = 1'b0;

        // Single fetch, latency 3
        if_req = 1'b1; if_addr = 16'h0010;
        sample();
        check_vec("f1_en", 32'({ram_en, ram_wr}), 32'b10);
        check_vec("f1_addr", 32'(ram_addr), 32'h0010);
        check_vec("f1_stall_t", 32'(stall_IF), 32'd1);
        tick();
        sample();
        check_vec("f1_en_t1", 32'({ram_en, if_done}), 32'd0);
        check_vec("f1_addr_t1", 32'(ram_addr), 32'h0010);
        check_vec("f1_stall_t1", 32'(stall_IF), 32'd1);
        tick();
        sample();
        check_vec("f1_stall_t2", 32'({stall_IF, if_done}), 32'b10);
        tick();
        ram_done = 1'b1; ram_rdata = 16'h1234;
        sample();
        check_vec("f1_done", 32'(if_done), 32'd1);
        check_vec("f1_rdata", 32'(if_rdata), 32'h1234);
        check_vec("f1_stall_t3", 32'(stall_IF), 32'd0);
        tick();
        idle_inputs();
        ram_done = 1'b1; ram_rdata = 16'hFFFF;
        sample();
        check_vec("idle_late_done", 32'({ram_en, if_done, mem_done}), 32'd0);
        tick();
        idle_inputs();

        // Store and fetch together: store first
        mem_req = 1'b1; mem_wr = 1'b1; mem_addr = 16'h0040; mem_wdata = 16'hBEEF;
        if_req = 1'b1; if_addr = 16'h0012;
        sample();
        check_vec("pri_en_wr", 32'({ram_en, ram_wr}), 32'b11);
        check_vec("pri_addr", 32'(ram_addr), 32'h0040);
        check_vec("pri_wdata", 32'(ram_wdata), 32'hBEEF);
        check_vec("pri_stalls", 32'({stall_IF, stall_MEM}), 32'b11);
        tick();
        ram_done = 1'b1;
        sample();
        check_vec("pri_mem_done", 32'({mem_done, stall_MEM, stall_IF, ram_en}), 32'b1010);
        check_vec("pri_hold_wdata", 32'(ram_wdata), 32'hBEEF);
        tick();
        mem_req = 1'b0; mem_wr = 1'b0; ram_done = 1'b0;
        sample();
        check_vec("pri_if_issue", 32'({ram_en, ram_wr, stall_IF}), 32'b101);
        check_vec("pri_if_addr", 32'(ram_addr), 32'h0012);
        tick();
        ram_done = 1'b1; ram_rdata = 16'h5678;
        sample();
        check_vec("pri_if_done", 32'({if_done, stall_IF}), 32'b10);
        check_vec("pri_if_rdata", 32'(if_rdata), 32'h5678);
        tick();
        idle_inputs();

        // Flushed fetch drains; pending load waits
        if_req = 1'b1; if_addr = 16'h0014;
        sample();
        check_vec("fl_issue", 32'(ram_en), 32'd1);
        tick();
        if_flush = 1'b1;
        mem_req = 1'b1; mem_addr = 16'h0020;
        sample();
        check_vec("fl_t1", 32'({if_done, stall_IF, ram_en, mem_done}), 32'd0);
        tick();
        if_flush = 1'b0; if_req = 1'b0;
        sample();
        check_vec("fl_drain_t2", 32'({ram_en, mem_done, stall_MEM}), 32'b001);
        check_vec("fl_drain_addr", 32'(ram_addr), 32'h0014);
        tick();
        sample();
        check_vec("fl_drain_t3", 32'({ram_en, mem_done, stall_MEM}), 32'b001);
        tick();
        ram_done = 1'b1; ram_rdata = 16'hDEAD;
        sample();
        check_vec("fl_drain_done", 32'({if_done, mem_done, ram_en, stall_MEM}), 32'b0001);
        check_vec("fl_drain_rdata", 32'({if_rdata, mem_rdata}), 32'd0);
        tick();
        ram_done = 1'b0;
        sample();
        check_vec("fl_ld_issue", 32'({ram_en, ram_wr}), 32'b10);
        check_vec("fl_ld_addr", 32'(ram_addr), 32'h0020);
        tick();
        ram_done = 1'b1; ram_rdata = 16'hCAFE;
        sample();
        check_vec("fl_ld_done", 32'(mem_done), 32'd1);
        check_vec("fl_ld_rdata", 32'(mem_rdata), 32'hCAFE);
        tick();
        idle_inputs();

        // Misaligned load
        mem_req = 1'b1; mem_addr = 16'h0041;
        sample();
        check_vec("mis_err_done", 32'({err, mem_done, ram_en, stall_MEM}), 32'b1100);
        check_vec("mis_rdata", 32'(mem_rdata), 32'd0);
        tick();
        idle_inputs();
        sample();
        check_vec("mis_err_clear", 32'({err, ram_en}), 32'd0);
        tick();

        // Reset during BUSY_MEM, then late ram_done
        mem_req = 1'b1; mem_addr = 16'h0030;
        sample();
        check_vec("rm_issue", 32'(ram_en), 32'd1);
        tick();
        rst = 1'b1;
        sample();
        check_vec("rm_in_rst", 32'({ram_en, mem_done, stall_MEM, err, if_done}), 32'd0);
        check_vec("rm_in_rst_addr", 32'(ram_addr), 32'd0);
        tick();
        rst = 1'b0; mem_req = 1'b0; ram_done = 1'b1; ram_rdata = 16'h7777;
        sample();
        check_vec("rm_state", 32'(dut.state), 32'd0);
        check_vec("rm_late_done", 32'({mem_done, if_done, ram_en}), 32'd0);
        check_vec("rm_rdata", 32'(mem_rdata), 32'd0);
        tick();
        idle_inputs();

        // Five back-to-back fetches, latency 1
        begin
            int dones;
            dones = 0;
            if_req = 1'b1;
            for (int i = 0; i < 5; i++) begin
                logic [15:0] a;
                a = 16'h0100 + 16'(2 * i);
                if_addr = a; ram_done = 1'b0;
                sample();
                check_vec($sformatf("b2b_en_%0d", i), 32'(ram_en), 32'd1);
                check_vec($sformatf("b2b_addr_%0d", i), 32'(ram_addr), 32'(a));
                tick();
                ram_done = 1'b1; ram_rdata = a ^ 16'hA5A5;
                sample();
                if (if_done) dones++;
                check_vec($sformatf("b2b_rdata_%0d", i), 32'(if_rdata), 32'(a ^ 16'hA5A5));
                tick();
            end
            check_vec("b2b_count", 32'(dones), 32'd5);
        end
        idle_inputs();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Hard bound so the bench always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule
